// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse generator: FSM state encoding,
// the minimum inter-pulse gap and the zero-width saturation rule.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int MIN_GAP = 1;

  // A requested width of zero still produces a one-cycle pulse.
  function automatic int unsigned w_eff(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_gen_if.sv
// Trigger request / pulse output bundle of the pulse generator.
// The master drives trig/width, the slave (generator) returns the status.
interface pulse_gen_if #(
  parameter int CNT_W = 8
) ();

  logic             trig;
  logic [CNT_W-1:0] width;
  logic             sig_out;
  logic             busy;
  logic             done;
  logic             dropped;

  modport master (
    output trig,
    output width,
    input  sig_out,
    input  busy,
    input  done,
    input  dropped
  );

  modport slave (
    input  trig,
    input  width,
    output sig_out,
    output busy,
    output done,
    output dropped
  );

endinterface

// File: rtl/pulse_gen_cnt.sv
// Loadable down-counter shared by the HIGH and GAP phases of pulse_gen.
// Load wins over decrement; decrement saturates at zero so it never wraps.
module pulse_gen_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Trigger-to-pulse generator with a one-deep request queue and a guaranteed
// low gap between pulses. Define PULSE_GEN_RETRIG_EN to let a trigger during
// a pulse extend it instead of queueing a second pulse.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pulse_gen_if.slave   bus
);

  if (GAP_CYC < MIN_GAP) begin : g_gap_min_chk
    $error("pulse_gen: GAP_CYC must be at least MIN_GAP");
  end
  if (GAP_CYC > (2 ** CNT_W)) begin : g_gap_max_chk
    $error("pulse_gen: GAP_CYC-1 must fit in CNT_W bits");
  end

`ifdef PULSE_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

  state_t           state, state_nxt;
  logic             pending, pend_nxt;
  logic [CNT_W-1:0] pend_w, pend_w_nxt;
  logic             sig_q, sig_nxt;
  logic             done_q, done_nxt;
  logic             drop_q, drop_nxt;
  logic             queue_req;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic [CNT_W-1:0] trig_w;

  assign trig_w = CNT_W'(w_eff(32'(bus.width)));

  pulse_gen_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      pend_w  <= '0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pend_nxt;
      pend_w  <= pend_w_nxt;
      sig_q   <= sig_nxt;
      done_q  <= done_nxt;
      drop_q  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_nxt     = pending;
    pend_w_nxt   = pend_w;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    sig_nxt      = 1'b0;
    done_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    queue_req    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.trig) begin
          state_nxt    = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = trig_w - ONE;
          sig_nxt      = 1'b1;
        end
      end

      HIGH: begin
        sig_nxt = 1'b1;
        if (RETRIG && bus.trig) begin
          // Extension also covers the last high cycle, so no gap is inserted.
          cnt_load     = 1'b1;
          cnt_load_val = trig_w - ONE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_nxt    = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
          sig_nxt      = 1'b0;
          done_nxt     = 1'b1;
        end
        queue_req = !RETRIG && bus.trig;
      end

      GAP: begin
        if (!cnt_zero) begin
          cnt_dec   = 1'b1;
          queue_req = bus.trig;
        end else if (pending) begin
          // The queued request goes first; a coincident trigger refills the slot.
          state_nxt    = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = pend_w - ONE;
          sig_nxt      = 1'b1;
          pend_nxt     = bus.trig;
          if (bus.trig) begin
            pend_w_nxt = trig_w;
          end
        end else if (bus.trig) begin
          state_nxt    = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = trig_w - ONE;
          sig_nxt      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (queue_req) begin
      if (pending) begin
        drop_nxt = 1'b1;
      end else begin
        pend_nxt   = 1'b1;
        pend_w_nxt = trig_w;
      end
    end
  end

  assign bus.sig_out = sig_q;
  assign bus.done    = done_q;
  assign bus.dropped = drop_q;
  assign bus.busy    = (state != IDLE) || pending;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed table-driven bench for pulse_gen; expected outputs per cycle are
// packed as {sig_out, busy, done, dropped}.
module tb_pulse_gen;

  typedef struct {
    logic       trig;
    logic [7:0] width;
    logic [3:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_gen_if #(.CNT_W(8)) bus ();

  pulse_gen #(
    .CNT_W   (8),
    .GAP_CYC (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  int   s1_lo, s1_hi;

  task automatic add(input logic t, input logic [7:0] w, input logic [3:0] e);
    vec_t v;
    v.trig  = t;
    v.width = w;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] outs();
    return {bus.sig_out, bus.busy, bus.done, bus.dropped};
  endfunction

  task automatic check4(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: sig/busy/done/drop got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      bus.trig  = vecs[i].trig;
      bus.width = vecs[i].width;
      @(negedge clk);
      check4($sformatf("%s[%0d]", tag, i - lo), vecs[i].exp);
    end
  endtask

  initial begin
    int hi_cnt;
    bit seen_done;
    int s_all;

    bus.trig  = 1'b0;
    bus.width = 8'd0;

    // Scenario 1: width 3
    s1_lo = vecs.size();
    add(1, 3, 4'b0000); add(0, 3, 4'b1100); add(0, 3, 4'b1100); add(0, 3, 4'b1100);
    add(0, 3, 4'b0110); add(0, 3, 4'b0000); add(0, 3, 4'b0000);
    s1_hi = vecs.size();
    // Scenario 2: width 0 saturates to 1
    add(1, 0, 4'b0000); add(0, 0, 4'b1100); add(0, 0, 4'b0110); add(0, 0, 4'b0000);
    // Scenario 7: trigger in GAP with empty queue starts next pulse directly
    add(1, 1, 4'b0000); add(0, 1, 4'b1100); add(1, 1, 4'b0110); add(0, 1, 4'b1100);
    add(0, 1, 4'b0110); add(0, 1, 4'b0000);
`ifdef PULSE_GEN_RETRIG_EN
    // Scenario 3: retrigger w=2 at c2 ends pulse at c4
    add(1, 3, 4'b0000); add(0, 3, 4'b1100); add(1, 2, 4'b1100); add(0, 2, 4'b1100);
    add(0, 2, 4'b1100); add(0, 2, 4'b0110); add(0, 2, 4'b0000); add(0, 2, 4'b0000);
    // Scenario 4: triggers c0..c2 all extend, no drop
    add(1, 3, 4'b0000); add(1, 3, 4'b1100); add(1, 3, 4'b1100); add(0, 3, 4'b1100);
    add(0, 3, 4'b1100); add(0, 3, 4'b1100); add(0, 3, 4'b0110); add(0, 3, 4'b0000);
    // Scenario 5: width 4 at c0 and c2, one continuous pulse c1..c6
    add(1, 4, 4'b0000); add(0, 4, 4'b1100); add(1, 4, 4'b1100); add(0, 4, 4'b1100);
    add(0, 4, 4'b1100); add(0, 4, 4'b1100); add(0, 4, 4'b1100); add(0, 4, 4'b0110);
    add(0, 4, 4'b0000);
    // Scenario 8: retrigger on the last high cycle keeps HIGH
    add(1, 1, 4'b0000); add(1, 1, 4'b1100); add(1, 2, 4'b1100); add(0, 2, 4'b1100);
    add(0, 2, 4'b1100); add(0, 2, 4'b0110); add(0, 2, 4'b0000);
`else
    // Scenario 3: queued second pulse of width 2
    add(1, 3, 4'b0000); add(0, 3, 4'b1100); add(1, 2, 4'b1100); add(0, 2, 4'b1100);
    add(0, 2, 4'b0110); add(0, 2, 4'b1100); add(0, 2, 4'b1100); add(0, 2, 4'b0110);
    add(0, 2, 4'b0000);
    // Scenario 4: c1 queued, c2 dropped
    add(1, 3, 4'b0000); add(1, 3, 4'b1100); add(1, 3, 4'b1100); add(0, 3, 4'b1101);
    add(0, 3, 4'b0110); add(0, 3, 4'b1100); add(0, 3, 4'b1100); add(0, 3, 4'b1100);
    add(0, 3, 4'b0110); add(0, 3, 4'b0000);
    // Scenario 5: width 4 at c0 and c2 gives two separate pulses
    add(1, 4, 4'b0000); add(0, 4, 4'b1100); add(1, 4, 4'b1100); add(0, 4, 4'b1100);
    add(0, 4, 4'b1100); add(0, 4, 4'b0110); add(0, 4, 4'b1100); add(0, 4, 4'b1100);
    add(0, 4, 4'b1100); add(0, 4, 4'b1100); add(0, 4, 4'b0110); add(0, 4, 4'b0000);
    // Scenario 8: pending consumed while a new trigger refills it
    add(1, 1, 4'b0000); add(1, 1, 4'b1100); add(1, 2, 4'b0110); add(0, 2, 4'b1100);
    add(0, 2, 4'b0110); add(0, 2, 4'b1100); add(0, 2, 4'b1100); add(0, 2, 4'b0110);
    add(0, 2, 4'b0000);
`endif
    s_all = vecs.size();

    #1;
    check4("reset_state", 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check4("reset_release", 4'b0000);

    run(0, s_all, "table");

    // Asynchronous reset in the middle of a width-5 pulse
    @(posedge clk); #1; bus.trig = 1'b1; bus.width = 8'd5;
    @(posedge clk); #1; bus.trig = 1'b0;
    @(posedge clk); #1;
    check4("rst_pre", 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check4("rst_async", 4'b0000);
    @(posedge clk); #1;
    check4("rst_hold", 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check4("rst_no_done", 4'b0000);
    run(s1_lo, s1_hi, "post_rst");

    // Maximum width 255
    @(posedge clk); #1; bus.trig = 1'b1; bus.width = 8'd255;
    @(posedge clk); #1; bus.trig = 1'b0;
    hi_cnt    = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 300 && !seen_done; k++) begin
      @(negedge clk);
      if (bus.sig_out) hi_cnt++;
      if (bus.done) seen_done = 1'b1;
    end
    check_int("max_width_high_cycles", hi_cnt, 255);
    check_int("max_width_done_seen", int'(seen_done), 1);
    @(negedge clk);
    check4("max_width_idle", 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
